// File: rtl/data_block_pkg.sv
// rtl/data_block_pkg.sv - shared constants and state type for the event readout path
package data_block_pkg;

    localparam int EVT_ADDR_W    = 10;
    localparam int SAMPLE_ADDR_W = 16;
    localparam int BLOCK_ADDR_W  = 4;
    localparam int EVT_FIELD_W   = 20;

    localparam logic [7:0] STATUS_FREE  = 8'h00;
    localparam logic [7:0] STATUS_VALID = 8'h01;
    localparam logic [3:0] HDR_TAG      = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_CHECK,
        ST_HDR,
        ST_FETCH,
        ST_SEND,
        ST_CLEAR
    } rd_state_e;

endpackage

// File: rtl/readout_word_serializer.sv
// rtl/readout_word_serializer.sv - splits one 64-bit sample into four 16-bit stream words, MSB first
module readout_word_serializer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        load_last,
    output logic        busy,
    output logic        done,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready
);

    logic [63:0] data_q, data_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        xfer;

    assign xfer     = valid_q & tx_ready;
    assign busy     = valid_q;
    assign tx_valid = valid_q;
    assign tx_data  = valid_q ? data_q[63:48] : 16'h0000;
    assign tx_last  = valid_q & last_q & (cnt_q == 2'd3);
    assign done     = xfer & (cnt_q == 2'd3);

    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load) begin
            data_d  = load_data;
            cnt_d   = 2'd0;
            valid_d = 1'b1;
            last_d  = load_last;
        end else if (xfer) begin
            data_d = {data_q[47:0], 16'h0000};
            cnt_d  = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/event_readout_sequencer.sv
// rtl/event_readout_sequencer.sv - polls Event Info RAM, streams framed events from Sample RAM, frees slots
module event_readout_sequencer
    import data_block_pkg::*;
#(
    parameter int EVT_ADDR_W     = 10,
    parameter int RAM_RD_LATENCY = 1
) (
    input  logic                  Clock,
    input  logic                  Reset_N,
    input  logic                  Readout_Enable,
    output logic [EVT_ADDR_W-1:0] Event_RAM_R_Address,
    input  logic [7:0]            Event_RAM_R_Data_Status,
    input  logic [19:0]           Event_RAM_R_Data_Start_ADDR,
    input  logic [19:0]           Event_RAM_R_Data_Number,
    input  logic [19:0]           Event_RAM_R_Data_Size,
    output logic                  Event_RAM_W_Enable_Status,
    output logic [7:0]            Event_RAM_W_Data_Status,
    output logic [15:0]           Sample_RAM_R_Address,
    output logic [3:0]            Sample_RAM_R_Block_Address,
    input  logic [63:0]           Sample_RAM_R_Data,
    output logic [15:0]           Tx_Data,
    output logic                  Tx_Valid,
    output logic                  Tx_Last,
    input  logic                  Tx_Ready,
    output logic                  Busy,
    output logic [15:0]           Events_Sent
);

    localparam logic [7:0] LAT   = 8'(RAM_RD_LATENCY);
    localparam logic [7:0] LAT_M = 8'(RAM_RD_LATENCY - 1);

    rd_state_e               state_q, state_d;
    logic [EVT_ADDR_W-1:0]   evt_ptr_q, evt_ptr_d;
    logic [EVT_FIELD_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [EVT_FIELD_W-1:0]  remaining_q, remaining_d;
    logic [EVT_FIELD_W-1:0]  number_q, number_d;
    logic [7:0]              status_q, status_d;
    logic [1:0]              hdr_idx_q, hdr_idx_d;
    logic [7:0]              wait_q, wait_d;
    logic [15:0]             sent_q, sent_d;

    logic        ser_load, ser_busy, ser_done, ser_valid, ser_last;
    logic [15:0] ser_data;
    logic [15:0] hdr_word;
    logic        in_hdr;

    readout_word_serializer u_ser (
        .clk       (Clock),
        .resetn    (Reset_N),
        .load      (ser_load),
        .load_data (Sample_RAM_R_Data),
        .load_last (remaining_q == 20'd1),
        .busy      (ser_busy),
        .done      (ser_done),
        .tx_data   (ser_data),
        .tx_valid  (ser_valid),
        .tx_last   (ser_last),
        .tx_ready  (Tx_Ready)
    );

    always_comb begin
        hdr_word = {remaining_q[7:0], 8'h00};
        case (hdr_idx_q)
            2'd0:    hdr_word = {HDR_TAG, number_q[19:8]};
            2'd1:    hdr_word = {number_q[7:0], status_q};
            2'd2:    hdr_word = {4'h0, remaining_q[19:8]};
            default: hdr_word = {remaining_q[7:0], 8'h00};
        endcase
    end

    // Header words are generated here; payload words come from the serializer.
    assign in_hdr   = (state_q == ST_HDR);
    assign Tx_Valid = in_hdr | ser_valid;
    assign Tx_Data  = in_hdr ? hdr_word : ser_data;
    assign Tx_Last  = in_hdr ? ((hdr_idx_q == 2'd3) && (remaining_q == '0)) : ser_last;

    assign Event_RAM_R_Address        = evt_ptr_q;
    assign Event_RAM_W_Enable_Status  = (state_q == ST_CLEAR);
    assign Event_RAM_W_Data_Status    = STATUS_FREE;
    assign Sample_RAM_R_Block_Address = rd_ptr_q[EVT_FIELD_W-1:SAMPLE_ADDR_W];
    assign Sample_RAM_R_Address       = rd_ptr_q[SAMPLE_ADDR_W-1:0];
    assign Busy                       = (state_q != ST_IDLE);
    assign Events_Sent                = sent_q;

    always_comb begin
        state_d     = state_q;
        evt_ptr_d   = evt_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        number_d    = number_q;
        status_d    = status_q;
        hdr_idx_d   = hdr_idx_q;
        wait_d      = wait_q;
        sent_d      = sent_q;
        ser_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (Readout_Enable) begin
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                if (wait_q == LAT_M) begin
                    wait_d  = '0;
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_CHECK: begin
                // A non-valid slot is re-polled from IDLE without advancing.
                if (Event_RAM_R_Data_Status == STATUS_VALID) begin
                    number_d    = Event_RAM_R_Data_Number;
                    rd_ptr_d    = Event_RAM_R_Data_Start_ADDR;
                    remaining_d = Event_RAM_R_Data_Size;
                    status_d    = Event_RAM_R_Data_Status;
                    hdr_idx_d   = 2'd0;
                    state_d     = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (Tx_Ready) begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd3) begin
                        wait_d  = '0;
                        state_d = (remaining_q != '0) ? ST_FETCH : ST_CLEAR;
                    end
                end
            end
            ST_FETCH: begin
                // The address has been stable since entry, so data is valid after LAT clocks.
                if ((wait_q == LAT) && !ser_busy) begin
                    ser_load = 1'b1;
                    wait_d   = '0;
                    state_d  = ST_SEND;
                end else if (wait_q != LAT) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_SEND: begin
                if (ser_done) begin
                    remaining_d = remaining_q - 20'd1;
                    rd_ptr_d    = rd_ptr_q + 20'd1;
                    state_d     = (remaining_q != 20'd1) ? ST_FETCH : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                evt_ptr_d = evt_ptr_q + 1'b1;
                sent_d    = sent_q + 16'd1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            state_q     <= ST_IDLE;
            evt_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            number_q    <= '0;
            status_q    <= '0;
            hdr_idx_q   <= '0;
            wait_q      <= '0;
            sent_q      <= '0;
        end else begin
            state_q     <= state_d;
            evt_ptr_q   <= evt_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            number_q    <= number_d;
            status_q    <= status_d;
            hdr_idx_q   <= hdr_idx_d;
            wait_q      <= wait_d;
            sent_q      <= sent_d;
        end
    end

endmodule
